// File: rtl/dct_coef_deser.sv
// Serial-to-parallel deserialiser for the DCT core's coefficient stream.
// Collects MSB-first bits into signed words and tags each word with its
// index in the transform row and a last flag. Words are then buffered in a
// small first-word-fall-through FIFO that feeds the quantiser.
module dct_coef_deser #(
  parameter int COEF_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iSDAT,
  input  logic              iSVAL,
  input  logic [2:0]        iSize,
  input  logic              iCoefReady,
  input  logic              iClrErr,
  output logic [COEF_W-1:0] oCoef,
  output logic [4:0]        oCoefIdx,
  output logic              oLast,
  output logic              oCoefValid,
  output logic              oOverflow,
  output logic              oFrameErr
);

  localparam int CW = $clog2(COEF_W);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(COEF_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  typedef struct packed {
    logic [COEF_W-1:0] coef;
    logic [4:0]        idx;
    logic              last;
  } entry_t;

  state_t            state, state_nxt;
  logic [COEF_W-1:0] shreg;
  logic [CW-1:0]     bitcnt;
  logic [1:0]        size_q;
  logic [4:0]        idx;
  logic [4:0]        last_idx;
  logic              shift_en, word_done, frame_err;

  entry_t            mem [FIFO_DEPTH];
  entry_t            head, push_ent;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, empty, pop, push_ok, ovf_set;

  // Next-state and per-cycle strobes of the word framer
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    word_done = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        if (iSVAL) begin
          shift_en  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (iSVAL) begin
          shift_en = 1'b1;
          if (bitcnt == BIT_LAST) begin
            word_done = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          frame_err = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Framer state register
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Shift register, bit counter, row size and coefficient index
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      shreg  <= '0;
      bitcnt <= '0;
      size_q <= '0;
      idx    <= '0;
    end else begin
      if (shift_en) shreg <= {shreg[COEF_W-2:0], iSDAT};
      if (word_done || frame_err) bitcnt <= '0;
      else if (shift_en)          bitcnt <= bitcnt + 1'b1;
      // Row size is sampled only at the first bit of a row's first word
      if (state == IDLE && iSVAL && idx == 5'd0)
        size_q <= (iSize > 3'd3) ? 2'd3 : iSize[1:0];
      // Dropped words still advance idx so row alignment survives overflow
      if (word_done) idx <= (idx == last_idx) ? 5'd0 : idx + 5'd1;
    end
  end

  // N-1 for N = 4 << size_q
  always_comb begin
    case (size_q)
      2'd0:    last_idx = 5'd3;
      2'd1:    last_idx = 5'd7;
      2'd2:    last_idx = 5'd15;
      default: last_idx = 5'd31;
    endcase
  end

  assign push_ent.coef = {shreg[COEF_W-2:0], iSDAT};
  assign push_ent.idx  = idx;
  assign push_ent.last = (idx == last_idx);

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = !empty && iCoefReady;
  assign push_ok = word_done && (!full || pop);
  assign ovf_set = word_done && full && !pop;

  // FIFO storage; contents need no reset since the head is gated by empty
  always_ff @(posedge iClk) begin
    if (push_ok) mem[wr_ptr] <= push_ent;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a new event in the clear cycle keeps the flag set
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oOverflow <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      if (ovf_set)      oOverflow <= 1'b1;
      else if (iClrErr) oOverflow <= 1'b0;
      if (frame_err)    oFrameErr <= 1'b1;
      else if (iClrErr) oFrameErr <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr];
  assign oCoefValid = !empty;
  assign oCoef      = empty ? '0   : head.coef;
  assign oCoefIdx   = empty ? 5'd0 : head.idx;
  assign oLast      = empty ? 1'b0 : head.last;

endmodule

// File: tb/tb_dct_coef_deser.sv
// Directed bench for dct_coef_deser: table of streamed words with expected
// tags, plus hand sequences for overflow, full push+pop, framing and reset.
module tb_dct_coef_deser;

  logic        iClk = 1'b0;
  logic        iRst_n;
  logic        iSDAT, iSVAL, iCoefReady, iClrErr;
  logic [2:0]  iSize;
  logic [15:0] oCoef;
  logic [4:0]  oCoefIdx;
  logic        oLast, oCoefValid, oOverflow, oFrameErr;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  size;
    logic [15:0] word;
    logic [4:0]  idx;
    logic        last;
  } vec_t;

  vec_t tbl [16];

  dct_coef_deser #(.COEF_W(16), .FIFO_DEPTH(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iSDAT(iSDAT), .iSVAL(iSVAL),
    .iSize(iSize), .iCoefReady(iCoefReady), .iClrErr(iClrErr),
    .oCoef(oCoef), .oCoefIdx(oCoefIdx), .oLast(oLast),
    .oCoefValid(oCoefValid), .oOverflow(oOverflow), .oFrameErr(oFrameErr)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic bit_cyc(input logic b);
    iSVAL = 1'b1;
    iSDAT = b;
    @(posedge iClk); #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) bit_cyc(w[i]);
  endtask

  task automatic idle_cyc(input int n);
    iSVAL = 1'b0;
    iSDAT = 1'b0;
    repeat (n) begin @(posedge iClk); #1; end
  endtask

  task automatic clr_err();
    iClrErr = 1'b1;
    @(posedge iClk); #1;
    iClrErr = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    // 4-point row, then an 8-point row whose iSize drops to 0 at idx 3
    // (ignored), then a 4-point row using the new size
    tbl[0] = '{3'd0, 16'h0001, 5'd0, 1'b0};
    tbl[1] = '{3'd0, 16'h8000, 5'd1, 1'b0};
    tbl[2] = '{3'd0, 16'h7FFF, 5'd2, 1'b0};
    tbl[3] = '{3'd0, 16'hFFFF, 5'd3, 1'b1};
    for (int k = 0; k < 8; k++)
      tbl[4+k] = '{(k < 3) ? 3'd1 : 3'd0, 16'h1100 + 16'(k), 5'(k), k == 7};
    for (int k = 0; k < 4; k++)
      tbl[12+k] = '{3'd0, 16'h2200 + 16'(k), 5'(k), k == 3};

    iRst_n = 1'b0; iSDAT = 1'b0; iSVAL = 1'b0; iSize = 3'd0;
    iCoefReady = 1'b0; iClrErr = 1'b0;
    #12;
    chk("rst valid", oCoefValid, 0);
    chk("rst coef", oCoef, 0);
    chk("rst idx", oCoefIdx, 0);
    chk("rst last", oLast, 0);
    chk("rst ovf", oOverflow, 0);
    chk("rst ferr", oFrameErr, 0);
    @(negedge iClk); iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Table: back-to-back words, consumer always ready
    iCoefReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      iSize = tbl[i].size;
      w = tbl[i].word;
      for (int b = 15; b >= 1; b--) bit_cyc(w[b]);
      chk($sformatf("tbl%0d prevalid", i), oCoefValid, 0);
      bit_cyc(w[0]);
      chk($sformatf("tbl%0d valid", i), oCoefValid, 1);
      chk($sformatf("tbl%0d coef", i), oCoef, tbl[i].word);
      chk($sformatf("tbl%0d idx", i), oCoefIdx, tbl[i].idx);
      chk($sformatf("tbl%0d last", i), oLast, tbl[i].last);
    end
    idle_cyc(1);
    chk("tbl drained", oCoefValid, 0);

    // 32-point row into a stalled FIFO: only the first four survive
    iSize = 3'd3;
    iCoefReady = 1'b0;
    for (int k = 0; k < 32; k++) send_word(16'(k));
    idle_cyc(1);
    chk("ovf flag", oOverflow, 1);
    chk("ovf ferr", oFrameErr, 0);
    iCoefReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf drain%0d valid", k), oCoefValid, 1);
      chk($sformatf("ovf drain%0d coef", k), oCoef, k);
      chk($sformatf("ovf drain%0d idx", k), oCoefIdx, k);
      @(posedge iClk); #1;
    end
    chk("ovf empty", oCoefValid, 0);
    for (int k = 0; k < 32; k++) begin
      send_word(16'h0300 + 16'(k));
      chk($sformatf("row2 %0d coef", k), oCoef, 16'h0300 + k);
      chk($sformatf("row2 %0d idx", k), oCoefIdx, k);
      chk($sformatf("row2 %0d last", k), oLast, k == 31);
    end
    idle_cyc(1);
    clr_err();
    chk("ovf cleared", oOverflow, 0);

    // Full FIFO: word completes in a pop cycle, so push+pop, no overflow
    iCoefReady = 1'b0;
    for (int k = 0; k < 4; k++) send_word(16'h0400 + 16'(k));
    w = 16'h0404;
    for (int b = 15; b >= 1; b--) bit_cyc(w[b]);
    iCoefReady = 1'b1;
    bit_cyc(w[0]);
    iCoefReady = 1'b0;
    iSVAL = 1'b0;
    chk("full pp ovf", oOverflow, 0);
    chk("full pp coef", oCoef, 16'h0401);
    iCoefReady = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("full drain%0d coef", k), oCoef, 16'h0400 + k);
      chk($sformatf("full drain%0d idx", k), oCoefIdx, k);
      @(posedge iClk); #1;
    end
    chk("full empty", oCoefValid, 0);

    // Framing error after 7 bits; idx stays at 5
    iCoefReady = 1'b0;
    for (int b = 0; b < 7; b++) bit_cyc(b[0]);
    idle_cyc(1);
    chk("ferr flag", oFrameErr, 1);
    chk("ferr nopush", oCoefValid, 0);
    send_word(16'h1234);
    iSVAL = 1'b0;
    chk("ferr next coef", oCoef, 16'h1234);
    chk("ferr next idx", oCoefIdx, 5);
    clr_err();
    chk("ferr cleared", oFrameErr, 0);
    // Error and clear in the same cycle: set wins
    for (int b = 0; b < 3; b++) bit_cyc(1'b1);
    iSVAL = 1'b0;
    clr_err();
    chk("ferr set wins", oFrameErr, 1);
    clr_err();
    chk("ferr cleared2", oFrameErr, 0);
    iCoefReady = 1'b1;
    @(posedge iClk); #1;
    chk("ferr popped", oCoefValid, 0);

    // Asynchronous reset mid-word with two words buffered
    iCoefReady = 1'b0;
    iSize = 3'd0;
    send_word(16'h0501);
    send_word(16'h0502);
    for (int b = 0; b < 5; b++) bit_cyc(1'b1);
    #2;
    iSVAL = 1'b0;
    iRst_n = 1'b0;
    #1;
    chk("arst valid", oCoefValid, 0);
    chk("arst coef", oCoef, 0);
    chk("arst idx", oCoefIdx, 0);
    #3;
    iRst_n = 1'b1;
    @(posedge iClk); #1;
    send_word(16'hA5A5);
    iSVAL = 1'b0;
    chk("post rst valid", oCoefValid, 1);
    chk("post rst coef", oCoef, 16'hA5A5);
    chk("post rst idx", oCoefIdx, 0);
    iCoefReady = 1'b1;
    @(posedge iClk); #1;
    chk("post rst only", oCoefValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dct_coef_deser.md
Name: dct_coef_deser

Overview:
- Downstream consumer of the 32-point DCT core's serial output stream (oSDAT/oSVAL).
- Deserialises MSB-first coefficient bits into COEF_W-bit signed words.
- Tags each word with its index within the transform row and marks the last one.
- Buffers words in a small first-word-fall-through FIFO behind a valid/ready handshake toward the quantiser.

Parameters:
- COEF_W, 16, coefficient width in bits; bits per serial word.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, at least 2.

Ports:
- iClk  input  1  system clock; all logic rising-edge.
- iRst_n  input  1  asynchronous active-low reset.
- iSDAT  input  1  serial coefficient bit, from the DCT core's oSDAT.
- iSVAL  input  1  serial bit valid, from the DCT core's oSVAL.
- iSize  input  3  transform size code: 0=4, 1=8, 2=16, 3=32 points; 4-7 treated as 32.
- iCoefReady  input  1  downstream ready.
- iClrErr  input  1  synchronous clear of the sticky error flags.
- oCoef  output  COEF_W  coefficient at FIFO head.
- oCoefIdx  output  5  index of the head coefficient within its row (0..N-1).
- oLast  output  1  head coefficient is index N-1.
- oCoefValid  output  1  FIFO not empty.
- oOverflow  output  1  sticky: a completed word was dropped because the FIFO was full.
- oFrameErr  output  1  sticky: iSVAL deasserted mid-word.

Behaviour:
- Interface (decided): single clock iClk; reset iRst_n is asynchronous, active-low.
- Reset values:
  - oCoef, oCoefIdx, oLast, oCoefValid, oOverflow, oFrameErr all 0.
  - FIFO empty; bit count 0; coefficient index 0; FSM in IDLE.
  - Reset asserted mid-word or mid-row discards all partial and buffered data.
- FSM states:
  - IDLE: waiting for a word.
    - iSVAL=1: shift the bit in, set bitcnt=1, go to SHIFT.
    - If coefficient index = 0, latch iSize into size_q on this cycle. size_q holds for the whole row, so iSize changes mid-row are ignored.
  - SHIFT: each cycle with iSVAL=1, shift reg <= {reg[COEF_W-2:0], iSDAT} and increment bitcnt.
    - On the cycle the COEF_W-th bit arrives, the word completes: push {word, idx, last}, reset bitcnt to 0, go to IDLE.
    - The next word may start on the immediately following cycle (back-to-back words, no gap required).
    - iSVAL=0 with bitcnt in 1..COEF_W-1: framing error. Set oFrameErr, discard the partial word, bitcnt=0, go to IDLE. The coefficient index does not advance.
- Row tracking:
  - N = 4 << min(size_q, 3).
  - last = (idx == N-1). After pushing a word with last=1, idx wraps to 0; otherwise idx increments.
  - idx advances on every completed word, including words dropped on overflow, so row alignment is preserved.
- FIFO:
  - First-word fall-through. oCoefValid = not empty; oCoef, oCoefIdx and oLast show the head entry.
  - Pop when oCoefValid & iCoefReady.
  - Push is accepted when not full, or when full and a pop occurs in the same cycle (simultaneous push+pop on full succeeds; count unchanged).
  - Push while full without a pop: word dropped, oOverflow set.
  - Simultaneous push+pop on empty: the pushed word appears at the head on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: the word completes on the cycle its last bit is sampled; oCoefValid is high (if the FIFO was empty) on the next rising edge.
- Errors:
  - iClrErr=1 clears both sticky flags on the next edge.
  - If a set event and iClrErr occur in the same cycle, the set wins.
  - Error flags do not stall deserialisation.
- Outputs are registered or FIFO-RAM-read combinationally from registered pointers; no combinational path from iSDAT to any output.

Test Plan:
- Reset, then iSize=0, 4 back-to-back 16-bit words 0x0001, 0x8000, 0x7FFF, 0xFFFF with iCoefReady=1 -> same values out in order, idx 0..3, oLast only on 0xFFFF, each oCoefValid 1 cycle after the word's final bit.
- iSize=3, 32 words 0x0000..0x001F with iCoefReady=0 until all are sent -> first 4 buffered; words 4..31 dropped and oOverflow=1. Then drain -> idx 0..3. A following row starts at idx 0 and oLast fires at idx 31.
- FIFO full (4 entries), word completes while iCoefReady=1 -> push and pop in the same cycle, count stays 4, oOverflow remains 0.
- 7 bits sent, then iSVAL=0 -> oFrameErr=1, no push. Next full word 0x1234 appears with the unchanged idx. iClrErr=1 clears oFrameErr next cycle.
- iSize changed from 1 to 0 at idx 3 of an 8-point row -> oLast at idx 7; the next row uses N=4.
- iRst_n pulsed low asynchronously mid-word with 2 words buffered -> outputs 0 immediately; after release, a word of 0xA5A5 produces only 0xA5A5 at idx 0.
